// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide with HI/LO registers.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they alias MULTU/DIVU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] a_raw;
  logic             dz;

  logic issue;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic last;
  logic commit;

  assign issue   = start && !flush && (state == IDLE);
  assign is_mul  = (funct == 6'd24) || (funct == 6'd25);
  assign is_div  = (funct == 6'd26) || (funct == 6'd27);
  assign is_mthi = (funct == 6'd17);
  assign is_mtlo = (funct == 6'd19);
  assign last    = (cnt == LAST);

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef MULDIV_SIGNED_EN
  logic sgn_op;
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  assign sgn_op = (funct == 6'd24) || (funct == 6'd26);
  assign a_neg  = sgn_op && rs_val[WIDTH-1];
  assign b_neg  = sgn_op && rt_val[WIDTH-1];
  assign a_mag  = a_neg ? -rs_val : rs_val;
  assign b_mag  = b_neg ? -rt_val : rt_val;

  // Result signs: product/quotient follow a^b, remainder follows dividend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (issue && (is_mul || is_div)) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  assign a_mag = rs_val;
  assign b_mag = rt_val;
`endif

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] prod_nx;
  logic [WIDTH:0]   div_tmp;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // prod = {acc, multiplier}; quo shifts dividend bits out, quotient in.
  always_comb begin
    mul_sum = prod[2*WIDTH:WIDTH];
    if (prod[0]) begin
      mul_sum = mul_sum + {1'b0, opb};
    end
    prod_nx  = {1'b0, mul_sum, prod[WIDTH-1:1]};
    div_tmp  = {rem, quo[WIDTH-1]};
    div_diff = div_tmp - {1'b0, opb};
    div_ge   = div_tmp >= {1'b0, opb};
    rem_nx   = div_ge ? div_diff[WIDTH-1:0]
                      : div_tmp[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   hi_c;
  logic [WIDTH-1:0]   lo_c;

  always_comb begin
    prod_res = prod_nx[2*WIDTH-1:0];
    q_res    = quo_nx;
    r_res    = rem_nx;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod_res = -prod_res;
      q_res    = -q_res;
    end
    if (neg_r) begin
      r_res = -r_res;
    end
`endif
    hi_c = r_res;
    lo_c = q_res;
    unique case (1'b1)
      (state == MUL): begin
        hi_c = prod_res[2*WIDTH-1:WIDTH];
        lo_c = prod_res[WIDTH-1:0];
      end
      dz: begin
        hi_c = a_raw;
        lo_c = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue && is_mul) begin
          state_nx = MUL;
        end else if (issue && is_div) begin
          state_nx = DIV;
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = IDLE;
          commit   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      opb   <= '0;
      a_raw <= '0;
      dz    <= 1'b0;
    end else if (state == IDLE) begin
      if (issue && (is_mul || is_div)) begin
        cnt   <= '0;
        opb   <= b_mag;
        a_raw <= rs_val;
        dz    <= is_div && (rt_val == '0);
        prod  <= {{(WIDTH+1){1'b0}}, a_mag};
        rem   <= '0;
        quo   <= a_mag;
      end
    end else begin
      cnt <= cnt + CW'(1);
      if (state == MUL) begin
        prod <= prod_nx;
      end else begin
        rem <= rem_nx;
        quo <= quo_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= (state_nx != IDLE);
      done     <= commit;
      div_zero <= commit && (state == DIV) && dz;
      if (commit) begin
        hi <= hi_c;
        lo <= lo_c;
      end else if (issue && is_mthi) begin
        hi <= rs_val;
      end else if (issue && is_mtlo) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline, executing MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Sits beside the EX-stage ALU. The ALU control routes R-type funct codes 24-27 and 17/19 here instead of to the single-cycle ALU.
- Raises busy so the hazard unit stalls MFHI/MFLO and new mul/div ops until results are committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, full product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  op issue strobe from EX stage, sampled on rising clk edge.
- funct  input  6  R-type funct: 17 MTHI, 19 MTLO, 24 MULT, 25 MULTU, 26 DIV, 27 DIVU; all others are no-op.
- rs_val  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source).
- rt_val  input  WIDTH  operand B (multiplier / divisor).
- flush  input  1  cancel in-flight op (branch/exception flush).
- busy  output  1  registered; 1 while an op is in flight.
- done  output  1  registered; one-cycle pulse when HI/LO commit from mul/div.
- div_zero  output  1  registered; one-cycle pulse, coincident with done, for DIV/DIVU with rt_val==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; iteration counter and working registers cleared. A reset mid-operation abandons the op and produces no done.
- States: IDLE, MUL, DIV.
- IDLE with start=1:
  - funct 24/25 -> MUL.
  - funct 26/27 -> DIV.
  - funct 17 -> hi<=rs_val at that edge, stay IDLE, no busy, no done.
  - funct 19 -> lo<=rs_val the same way.
  - Other funct -> no effect.
- Operand latch: rs_val/rt_val are captured at the start edge. Later changes on the inputs have no effect on the op in flight.
- MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH iterations.
- DIV: restoring division, one quotient bit per cycle, WIDTH iterations.
- Signed ops (24/26): operands are converted to magnitudes at start and the sign is fixed up at commit.
  - MULT: 2*WIDTH-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1: lo = most-negative value, hi = 0.
- Timing: with start sampled at edge E0, busy=1 for exactly WIDTH cycles (E0..E_WIDTH). At edge E_WIDTH:
  - hi/lo commit (MUL: hi=upper product half, lo=lower; DIV: lo=quotient, hi=remainder).
  - done=1 for one cycle, busy=0, state=IDLE.
- Back-to-back: start is accepted in the cycle done=1 (state already IDLE).
- start while busy=1 is ignored; the in-flight op is unaffected. The pipeline is responsible for stalling.
- Divide by zero (rt_val==0, signed or unsigned): full WIDTH-cycle latency is kept. Commit lo = all ones, hi = rs_val as latched; div_zero=1 together with done.
- flush=1 while busy: state=IDLE and busy=0 at that edge; hi/lo unchanged; no done.
- flush and start in the same IDLE cycle: flush wins, op not issued.
- flush in IDLE without start: no effect.
- Counter is ceil(log2(WIDTH+1)) bits; no wrap is possible within an op.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined: funct 24/26 perform signed MULT/DIV as described above.
- Undefined: funct 24/26 behave exactly as MULTU/DIVU (no magnitude conversion or sign fixup logic is synthesised). Latency and all other behaviour are identical.

Test Plan (WIDTH=32):
- Reset -> hi=0, lo=0, busy=0. MULTU 0xFFFFFFFF*2 at E0 -> busy high 32 cycles; at E32 hi=0x00000001, lo=0xFFFFFFFE, done pulse 1 cycle.
- DIVU 100/7 -> lo=14, hi=2 at E32. Immediately issue MTHI rs=0xDEADBEEF in the done cycle -> hi=0xDEADBEEF next edge, lo=14 unchanged, busy stays 0.
- With MULDIV_SIGNED_EN:
  - MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Without MULDIV_SIGNED_EN: MULT 0xFFFFFFFD*5 -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 5/0 -> at E32 lo=0xFFFFFFFF, hi=5, done=1 and div_zero=1 same cycle.
- Flush and collision cases:
  - MULTU started with hi/lo = 0x11/0x22, flush at cycle 10 -> busy=0 next edge, no done, hi/lo remain 0x11/0x22.
  - start DIVU at cycle 5 during a MULTU -> ignored; MULTU result correct.
  - rst asserted at cycle 20 of a DIV -> all outputs 0 immediately, no done.
